fb_line_writer: RTL and testbench
=================================

Name: fb_line_writer

Overview:
- Write-side counterpart of the scanline reader. Accepts one 640-pixel, 8-bit palette-index line at a time from a drawing engine via a valid/ready stream.
- Packs 16 pixels per 128-bit word and writes the 40 words of each line to the SDRAM back buffer through a request/acknowledge handshake.
- Selects the back buffer from frame_flip, so it always writes the buffer the reader is not displaying.

Parameters:
- BUF_A, 22'h100000, word base of frame buffer A (written when frame_flip=0).
- BUF_B, 22'h200000, word base of frame buffer B (written when frame_flip=1).
- WORDS_PER_LINE, 40, 128-bit words per line (640 px / 16).
- LINES, 480, visible lines per frame.

Ports:
- clock, in, 1, system clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- frame_flip, in, 1, display buffer select; sampled at line_start.
- new_frame, in, 1, one-cycle pulse at frame start; clears frame_done.
- line_start, in, 1, one-cycle pulse that begins a line; honoured only in IDLE.
- line_y, in, 10, line number, sampled with line_start.
- pix_valid, in, 1, pixel present on pix_index.
- pix_index, in, 8, palette index.
- pix_ready, out, 1, pixel accepted when pix_valid && pix_ready.
- sdram_wr, out, 1, write request.
- sdram_addr, out, 22, word address of the request.
- sdram_wdata, out, 128, write data; pixel n of the word sits in bits [8n+7:8n].
- sdram_ac, in, 1, acknowledge; completes the request in the cycle it is sampled high with sdram_wr.
- sdram_wait, in, 1, controller busy; blocks starting a new request.
- busy, out, 1, high in FILL and FLUSH.
- line_done, out, 1, one-cycle pulse when a line is fully written.
- frame_done, out, 1, sticky high after line LINES-1 completes; cleared by new_frame or reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; pend_valid 0; counters 0.
- Reset is synchronous and overrides everything, including mid-line. sdram_wr drops at the next edge and the partial line is discarded.
- State IDLE:
  - pix_ready=0.
  - On line_start with line_y < LINES: latch y, latch base (frame_flip ? BUF_B : BUF_A), clear pixel counter x (0..639), go to FILL.
  - line_start with line_y >= LINES is ignored (stay IDLE, no outputs).
- State FILL:
  - The pixel is accepted into byte lane x[3:0] of the fill register; x increments on each accept.
  - pix_ready=1, except when x[3:0]==15 and pend_valid==1 (stall until the pending word is acknowledged).
  - On accept at lane 15: pend_data <= filled word with the new byte, pend_addr <= base + y*WORDS_PER_LINE + x[9:4], pend_valid <= 1. There is no same-cycle reload on sdram_ac.
  - Accepting pixel x=639 moves the state to FLUSH.
- State FLUSH:
  - pix_ready=0.
  - When pend_valid==0: pulse line_done for one cycle; if y==LINES-1, set frame_done; go to IDLE.
- Write port:
  - sdram_wr rises only when pend_valid==1 and sdram_wait==0.
  - Once high, sdram_wr, sdram_addr and sdram_wdata are held stable until the cycle sdram_ac==1. sdram_wait is ignored while the request is outstanding.
  - In the acknowledge cycle pend_valid clears, and sdram_wr is 0 from the next cycle.
  - At most one outstanding request. Words are written strictly in order.
  - sdram_ac while sdram_wr==0 is ignored.
- Address arithmetic:
  - y*40 is computed in at least 15 bits and zero-extended.
  - The sum is truncated to 22 bits.
  - Maximum address: BUF_B + 479*40 + 39 = 22'h204AFF.
- Simultaneous events:
  - new_frame and frame_done set in the same cycle: frame_done ends set.
  - line_start while busy: ignored.
  - frame_flip changing mid-line: no effect until the next line_start.
- Latency: the lane-15 accept at edge N gives sdram_wr high at N+1 (if sdram_wait=0).

Test Plan:
- Basic line:
  - Stimulus: frame_flip=0, line_y=0, pix_index=x[7:0] streamed continuously, sdram_ac returned 1 cycle after sdram_wr, sdram_wait=0.
  - Required: first write addr 22'h100000, data 128'h0F0E0D0C0B0A09080706050403020100; 40 writes ending at 22'h100027; exactly one line_done; frame_done=0.
- Last line, buffer B:
  - Stimulus: frame_flip=1, line_y=479.
  - Required: writes span 22'h204AD8..22'h204AFF; frame_done rises with line_done and holds; a new_frame pulse clears it.
- Backpressure:
  - Stimulus: sdram_ac held 0 for 50 cycles on word 0, pix_valid constant 1.
  - Required: pixels x=16..30 accepted; pix_ready=0 at x=31 until the ack; addr/data stable throughout; no pixel lost or duplicated (verify all 40 words).
- Wait gating:
  - Stimulus: sdram_wait=1 when the first word completes, released 10 cycles later.
  - Required: sdram_wr stays 0 until the cycle after release.
  - Stimulus: sdram_wait raised after sdram_wr has risen.
  - Required: sdram_wr stays high until sdram_ac.
- Ignored commands:
  - Stimulus: line_start with line_y=480 in IDLE.
  - Required: no busy, no writes.
  - Stimulus: line_start during FILL.
  - Required: current line unaffected.
- Mid-line reset:
  - Stimulus: reset asserted at x=200 with a write outstanding.
  - Required: next cycle sdram_wr=0, busy=0, pix_ready=0. A following line_y=5 writes starting at 22'h1000C8 with correct data.

Source files
------------

// File: rtl/fb_line_writer.sv
// Frame-buffer line writer.
// Takes one line of 8-bit palette indices from a valid/ready pixel stream,
// packs 16 pixels into each 128-bit word and writes the words of the line
// into the SDRAM back buffer using a request/acknowledge handshake. The back
// buffer is chosen at line start from frame_flip, so the writer always fills
// the buffer the scanline reader is not showing.
module fb_line_writer #(
  parameter logic [21:0] BUF_A          = 22'h100000,
  parameter logic [21:0] BUF_B          = 22'h200000,
  parameter int          WORDS_PER_LINE = 40,
  parameter int          LINES          = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_flip,
  input  logic         new_frame,
  input  logic         line_start,
  input  logic [9:0]   line_y,
  input  logic         pix_valid,
  input  logic [7:0]   pix_index,
  output logic         pix_ready,
  output logic         sdram_wr,
  output logic [21:0]  sdram_addr,
  output logic [127:0] sdram_wdata,
  input  logic         sdram_ac,
  input  logic         sdram_wait,
  output logic         busy,
  output logic         line_done,
  output logic         frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [9:0] LAST_X   = 10'(WORDS_PER_LINE * 16 - 1);
  localparam logic [9:0] LAST_Y   = 10'(LINES - 1);
  localparam logic [9:0] NUM_ROWS = 10'(LINES);

  logic [1:0]   state;
  logic [9:0]   y_q;
  logic [21:0]  base_q;
  logic [9:0]   x_q;
  logic [119:0] fill_q;       // lanes 0..14; lane 15 comes straight from pix_index
  logic         pend_valid;
  logic [21:0]  pend_addr;
  logic [127:0] pend_data;
  logic         wr_q;
  logic         line_done_q;
  logic         frame_done_q;

  logic [3:0]   lane;
  logic         accept;
  logic         lane_last;
  logic [14:0]  line_offset;
  logic [21:0]  word_addr;
  logic         flush_done;

  assign lane      = x_q[3:0];
  assign lane_last = (lane == 4'hF);

  // The pixel that completes a word can only be taken once the previous word
  // has left the pending register, so ready drops on lane 15 while it is full.
  assign pix_ready = (state == S_FILL) && !(lane_last && pend_valid);
  assign accept    = pix_valid && pix_ready;

  // y*40 never exceeds 15 bits for 480 lines; zero-extend and wrap at 22 bits.
  assign line_offset = 15'(y_q) * 15'(WORDS_PER_LINE);
  assign word_addr   = base_q + {7'd0, line_offset} + {16'd0, x_q[9:4]};

  assign flush_done = (state == S_FLUSH) && !pend_valid;

  assign busy        = (state == S_FILL) || (state == S_FLUSH);
  assign sdram_wr    = wr_q;
  assign sdram_addr  = pend_addr;
  assign sdram_wdata = pend_data;
  assign line_done   = line_done_q;
  assign frame_done  = frame_done_q;

  // Line sequencing: latch line parameters in IDLE, count pixels in FILL,
  // wait for the final word to be acknowledged in FLUSH.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      y_q    <= '0;
      base_q <= '0;
      x_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line_start && (line_y < NUM_ROWS)) begin
            y_q    <= line_y;
            base_q <= frame_flip ? BUF_B : BUF_A;
            x_q    <= '0;
            state  <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            x_q <= x_q + 10'd1;
            if (x_q == LAST_X) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!pend_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte lanes 0..14 of the word being assembled.
  // NOTE: the fill register has no reset; every lane is overwritten before it
  // is ever copied to the pending word, so resetting it would only add fanout.
  always_ff @(posedge clock) begin
    if (accept && !lane_last) begin
      fill_q[{lane[3:0], 3'b000} +: 8] <= pix_index;
    end
  end

  // Pending word and the single outstanding SDRAM write request.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      wr_q       <= 1'b0;
    end else begin
      if (wr_q && sdram_ac) begin
        wr_q       <= 1'b0;
        pend_valid <= 1'b0;
      end else if (!wr_q && pend_valid && !sdram_wait) begin
        wr_q <= 1'b1;
      end
      // Loading never coincides with the acknowledge: lane 15 stalls while
      // pend_valid is set.
      if (accept && lane_last) begin
        pend_valid <= 1'b1;
        pend_addr  <= word_addr;
        pend_data  <= {pix_index, fill_q};
      end
    end
  end

  // Line and frame completion status.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      line_done_q <= flush_done;
      if (flush_done && (y_q == LAST_Y)) frame_done_q <= 1'b1;
      else if (new_frame)                frame_done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_line_writer.sv
// Self-checking bench for fb_line_writer: a table of whole-line vectors driven
// through a pixel source and SDRAM responder, with expected words queued at
// line start and compared as each write is acknowledged, plus hand-written
// sequences for ignored commands and mid-line reset.
module tb_fb_line_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         frame_flip = 1'b0;
  logic         new_frame = 1'b0;
  logic         line_start = 1'b0;
  logic [9:0]   line_y = '0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_index = '0;
  logic         pix_ready;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic         sdram_ac = 1'b0;
  logic         sdram_wait = 1'b0;
  logic         busy;
  logic         line_done;
  logic         frame_done;

  always #5 clock = ~clock;

  fb_line_writer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_flip  (frame_flip),
    .new_frame   (new_frame),
    .line_start  (line_start),
    .line_y      (line_y),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .pix_ready   (pix_ready),
    .sdram_wr    (sdram_wr),
    .sdram_addr  (sdram_addr),
    .sdram_wdata (sdram_wdata),
    .sdram_ac    (sdram_ac),
    .sdram_wait  (sdram_wait),
    .busy        (busy),
    .line_done   (line_done),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [21:0]  addr;
    logic [127:0] data;
  } wr_t;

  typedef struct {
    bit          flip;
    int          y;
    int          seed;
    int          dly;
    bit          bp;
    int          wmode;
    bit          mid;
    bit          pre_nf;
    bit          sim_nf;
    logic [21:0] first;
    logic [21:0] last;
    bit          fd;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  vec_t rst_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment state shared between the main sequence and the negedge agent.
  bit           pix_on = 1'b0;
  int           src_x = 0;
  int           seed_q = 0;
  int           ack_delay = 1;
  bit           bp_mode = 1'b0;
  int           wmode = 0;
  int           w1_state = 0;
  int           w1_cnt = 0;
  int           mon_count = 0;
  logic [21:0]  mon_first = '0;
  logic [21:0]  mon_last = '0;
  int           line_done_cnt = 0;
  logic         fd_at_done = 1'b0;
  int           ack_cnt = 0;
  bit           req_open = 1'b0;
  logic [21:0]  held_addr = '0;
  logic [127:0] held_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int x, input int seed);
    return 8'(x + seed + seed * (x / 256));
  endfunction

  // Negedge agent: protocol checks, SDRAM responder with scoreboard, pixel source.
  always @(negedge clock) begin
    int  dly;
    wr_t e;
    if (reset) begin
      sdram_ac  = 1'b0;
      pix_valid = 1'b0;
      req_open  = 1'b0;
      ack_cnt   = 0;
    end else begin
      if (req_open) begin
        check("wr_held", sdram_wr, 1);
        check("addr_held", sdram_addr, held_addr);
        check("data_held", sdram_wdata, held_data);
      end
      if (line_done) begin
        line_done_cnt++;
        fd_at_done = frame_done;
      end
      if (w1_state == 1) check("wait_block", sdram_wr, 0);
      if (w1_state == 2) begin
        check("wait_release", sdram_wr, 1);
        w1_state = 3;
      end

      if (sdram_wr) begin
        dly = (bp_mode && mon_count == 0) ? 50 : ack_delay;
        if (!req_open) begin
          held_addr = sdram_addr;
          held_data = sdram_wdata;
          ack_cnt   = 0;
          if (wmode == 2) sdram_wait = 1'b1;
        end
        if (ack_cnt >= dly) begin
          sdram_ac = 1'b1;
          req_open = 1'b0;
          if (bp_mode && mon_count == 0) begin
            check("bp_stall_x", src_x, 31);
            check("bp_ready_low", pix_ready, 0);
          end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_unexpected: got addr %0h expected no write", sdram_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", sdram_addr, e.addr);
            check("wr_data", sdram_wdata, e.data);
          end
          if (mon_count == 0) mon_first = sdram_addr;
          mon_last = sdram_addr;
          mon_count++;
          if (wmode == 2) sdram_wait = 1'b0;
          if (wmode == 1 && mon_count == 1 && w1_state == 0) begin
            sdram_wait = 1'b1;
            w1_state   = 1;
          end
        end else begin
          sdram_ac = 1'b0;
          req_open = 1'b1;
          ack_cnt++;
        end
      end else begin
        // Spurious acknowledges while blocked must be ignored by the design.
        sdram_ac = (w1_state == 1);
        req_open = 1'b0;
      end

      if (w1_state == 1 && src_x >= 32) begin
        w1_cnt++;
        if (w1_cnt >= 10) begin
          sdram_wait = 1'b0;
          w1_state   = 2;
        end
      end

      if (pix_on && src_x < 640) begin
        pix_valid = 1'b1;
        pix_index = pix_val(src_x, seed_q);
        if (pix_ready) src_x++;
      end else begin
        pix_valid = 1'b0;
        pix_index = '0;
      end
    end
  end

  // Called just after a posedge: set up the agent and queue the expected words.
  task automatic setup_line(input vec_t v);
    logic [21:0]  base;
    logic [127:0] d;
    seed_q        = v.seed;
    ack_delay     = v.dly;
    bp_mode       = v.bp;
    wmode         = v.wmode;
    w1_state      = 0;
    w1_cnt        = 0;
    sdram_wait    = 1'b0;
    mon_count     = 0;
    line_done_cnt = 0;
    src_x         = 0;
    pix_on        = 1'b1;
    base = v.flip ? 22'h200000 : 22'h100000;
    for (int w = 0; w < 40; w++) begin
      for (int n = 0; n < 16; n++) d[8*n +: 8] = pix_val(16*w + n, v.seed);
      exp_q.push_back('{addr: base + 22'(v.y*40 + w), data: d});
    end
  endtask

  task automatic run_line(input vec_t v);
    int guard;
    bit mid_done;
    bit nf_done;
    mid_done = 1'b0;
    nf_done  = 1'b0;
    if (v.pre_nf) begin
      @(negedge clock) new_frame = 1'b1;
      @(negedge clock) new_frame = 1'b0;
      check("nf_clear", frame_done, 0);
    end
    @(posedge clock); #1;
    setup_line(v);
    @(negedge clock);
    line_start = 1'b1;
    line_y     = 10'(v.y);
    frame_flip = v.flip;
    @(negedge clock) line_start = 1'b0;
    guard = 0;
    while (line_done_cnt == 0 && guard < 6000) begin
      @(posedge clock); #1;
      guard++;
      if (v.mid && !mid_done && src_x >= 100) begin
        mid_done = 1'b1;
        @(negedge clock);
        line_start = 1'b1;
        line_y     = 10'd9;
        frame_flip = !v.flip;
        @(negedge clock) line_start = 1'b0;
      end
      // Ack of the last word has just landed: new_frame meets frame_done set.
      if (v.sim_nf && !nf_done && mon_count == 40) begin
        nf_done = 1'b1;
        @(negedge clock) new_frame = 1'b1;
        @(negedge clock) new_frame = 1'b0;
      end
    end
    repeat (3) @(posedge clock);
    #1;
    check("line_done_count", line_done_cnt, 1);
    check("write_count", mon_count, 40);
    check("first_addr", mon_first, v.first);
    check("last_addr", mon_last, v.last);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pixels_taken", src_x, 640);
    check("fd_at_line_done", fd_at_done, v.fd);
    check("frame_done_hold", frame_done, v.fd);
    check("idle_after_line", busy, 0);
    pix_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    //          flip  y    seed  dly bp wm mid pre sim first       last        fd
    vecs[0] = '{1'b0, 0,   0,    1,  0, 0, 0,  0,  0,  22'h100000, 22'h100027, 1'b0};
    vecs[1] = '{1'b1, 1,   7,    0,  0, 1, 1,  0,  0,  22'h200028, 22'h20004F, 1'b0};
    vecs[2] = '{1'b0, 2,   9,    1,  1, 0, 0,  0,  0,  22'h100050, 22'h100077, 1'b0};
    vecs[3] = '{1'b0, 100, 3,    3,  0, 2, 0,  0,  0,  22'h100FA0, 22'h100FC7, 1'b0};
    vecs[4] = '{1'b1, 479, 'h5A, 1,  0, 0, 0,  0,  0,  22'h204AD8, 22'h204AFF, 1'b1};
    vecs[5] = '{1'b0, 479, 'h11, 2,  0, 0, 0,  1,  1,  22'h104AD8, 22'h104AFF, 1'b1};
    rst_vec = '{1'b0, 5,   'h21, 1,  0, 0, 0,  0,  0,  22'h1000C8, 22'h1000EF, 1'b0};

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_sdram_wr", sdram_wr, 0);
    check("rst_sdram_addr", sdram_addr, 0);
    check("rst_sdram_wdata", sdram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;

    foreach (vecs[i]) run_line(vecs[i]);

    // A lone new_frame clears the sticky flag.
    @(negedge clock) new_frame = 1'b1;
    @(negedge clock) new_frame = 1'b0;
    check("nf_pulse_clear", frame_done, 0);

    // Out-of-range line_start is ignored.
    @(posedge clock); #1;
    mon_count = 0;
    @(negedge clock);
    line_start = 1'b1;
    line_y     = 10'd480;
    @(negedge clock) line_start = 1'b0;
    check("bad_y_busy", busy, 0);
    check("bad_y_ready", pix_ready, 0);
    repeat (10) @(negedge clock);
    check("bad_y_busy_later", busy, 0);
    @(posedge clock); #1;
    check("bad_y_no_writes", mon_count, 0);

    // Mid-line reset with a request outstanding.
    setup_line('{1'b0, 7, 'h33, 30, 0, 0, 0, 0, 0, 22'h0, 22'h0, 1'b0});
    @(negedge clock);
    line_start = 1'b1;
    line_y     = 10'd7;
    frame_flip = 1'b0;
    @(negedge clock) line_start = 1'b0;
    guard = 0;
    do begin
      @(posedge clock); #1;
      guard++;
    end while (!(src_x >= 200 && sdram_wr && !sdram_ac) && guard < 6000);
    check("rst_point_reached", src_x >= 200 && sdram_wr, 1);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check("midrst_sdram_wr", sdram_wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    @(posedge clock); #1;
    pix_on = 1'b0;
    exp_q.delete();
    @(negedge clock) reset = 1'b0;
    run_line(rst_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
